// File: rtl/sha256_msg_padder_pkg.sv
// Shared definitions for the SHA-256 message padder: state encoding, block geometry, pad byte.
package sha256_msg_padder_pkg;

  localparam int          SHA256_BLOCK_WORDS = 16;
  localparam int          SHA256_LEN_WORD_HI = 14;
  localparam logic [7:0]  PAD_BYTE           = 8'h80;

  // Index of the last zero-fill word before the two length words.
  localparam logic [3:0]  LAST_PAD_WORD      = 4'(SHA256_LEN_WORD_HI - 1);
  localparam logic [3:0]  LAST_BLOCK_WORD    = 4'(SHA256_BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    ST_DATA     = 2'd0,
    ST_PAD_ZERO = 2'd1,
    ST_LEN_HI   = 2'd2,
    ST_LEN_LO   = 2'd3
  } pad_state_e;

endpackage

// File: rtl/sha256_msg_padder_word_packer.sv
// Byte-lane assembly for the padder: holds lanes 0..2 of the current word and builds
// the outgoing word with the new byte, an optional 0x80 terminator and zero fill.
module sha256_word_packer
  import sha256_msg_padder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  lane,
  input  logic [7:0]  data,
  input  logic        byte_en,
  input  logic        pad_en,
  input  logic        store,
  output logic [31:0] word
);

  logic [2:0][7:0] asm_q;
  logic [31:0]     held;
  logic [31:0]     keep_mask;
  logic [4:0]      sh_cur;
  logic [4:0]      sh_nxt;
  logic [7:0]      cur_byte;
  logic [7:0]      nxt_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
    end else if (store) begin
      case (lane)
        2'd0:    asm_q[2] <= data;
        2'd1:    asm_q[1] <= data;
        2'd2:    asm_q[0] <= data;
        default: ;
      endcase
    end
  end

  // Lane 0 is the MSB byte; lanes above the write lane are stale and masked off.
  always_comb begin
    held      = {asm_q[2], asm_q[1], asm_q[0], 8'h00};
    keep_mask = ~(32'hFFFF_FFFF >> {lane, 3'b000});
    sh_cur    = {~lane, 3'b000};
    sh_nxt    = sh_cur - 5'd8;
    cur_byte  = byte_en ? data : (pad_en ? PAD_BYTE : 8'h00);
    nxt_byte  = (byte_en && pad_en) ? PAD_BYTE : 8'h00;
    word      = (held & keep_mask) | ({24'h0, cur_byte} << sh_cur);
    if (lane != 2'd3) begin
      word = word | ({24'h0, nxt_byte} << sh_nxt);
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder top: byte stream in, 16-word padded blocks out on a valid/ready word stream.
// Optional block counter output enabled by defining SHA256_PADDER_BLKCNT_EN.
//
// state       | meaning
// ST_DATA     | accepting message bytes (idle when busy=0)
// ST_PAD_ZERO | emitting zero fill words (first one may be a pending 80000000)
// ST_LEN_HI   | emitting bit length [63:32] as word 14
// ST_LEN_LO   | emitting bit length [31:0] as word 15, final word of message
module sha256_msg_padder
  import sha256_msg_padder_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_nodata,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_final,
  output logic        busy
`ifdef SHA256_PADDER_BLKCNT_EN
  ,
  output logic [15:0] blk_cnt
`endif
);

  pad_state_e        state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [LEN_W-1:0]  bitlen_q, bitlen_d;
  logic              pad80_q, pad80_d;
  logic              busy_q;
  logic              rdy_en_q;

  logic              can_load;
  logic              accept;
  logic              out_fire;
  logic              load;
  logic [31:0]       load_word;
  logic              load_final;
  logic [31:0]       pk_word;
  logic [63:0]       len64;

  assign can_load = !out_valid || out_ready;
  assign in_ready = rdy_en_q && (state_q == ST_DATA) && can_load;
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign len64    = 64'(bitlen_q);
  assign busy     = busy_q;

  sha256_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .lane    (bcnt_q),
    .data    (in_data),
    .byte_en (!(in_last && in_nodata)),
    .pad_en  (in_last),
    .store   (accept && !in_last),
    .word    (pk_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_DATA;
      bcnt_q   <= '0;
      wcnt_q   <= '0;
      bitlen_q <= '0;
      pad80_q  <= 1'b0;
      busy_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      wcnt_q   <= wcnt_d;
      bitlen_q <= bitlen_d;
      pad80_q  <= pad80_d;
      rdy_en_q <= 1'b1;
      if (accept) begin
        busy_q <= 1'b1;
      end else if (out_fire && out_final) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Words are loaded only when the output register is empty or emptying, so wcnt
  // counts loads and stays in step with the consumer's handshakes.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    bitlen_d   = bitlen_q;
    pad80_d    = pad80_q;
    load       = 1'b0;
    load_word  = '0;
    load_final = 1'b0;
    case (state_q)
      ST_DATA: begin
        if (accept) begin
          if (!(in_last && in_nodata)) begin
            bitlen_d = bitlen_q + LEN_W'(8);
          end
          if (in_last) begin
            load      = 1'b1;
            load_word = pk_word;
            wcnt_d    = wcnt_q + 4'd1;
            bcnt_d    = '0;
            if (!in_nodata && (bcnt_q == 2'd3)) begin
              pad80_d = 1'b1;
              state_d = ST_PAD_ZERO;
            end else begin
              state_d = (wcnt_q == LAST_PAD_WORD) ? ST_LEN_HI : ST_PAD_ZERO;
            end
          end else if (bcnt_q == 2'd3) begin
            load      = 1'b1;
            load_word = pk_word;
            wcnt_d    = wcnt_q + 4'd1;
            bcnt_d    = '0;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      ST_PAD_ZERO: begin
        if (can_load) begin
          load      = 1'b1;
          load_word = pad80_q ? {PAD_BYTE, 24'h0} : 32'h0;
          pad80_d   = 1'b0;
          wcnt_d    = wcnt_q + 4'd1;
          if (wcnt_q == LAST_PAD_WORD) begin
            state_d = ST_LEN_HI;
          end
        end
      end
      ST_LEN_HI: begin
        if (can_load) begin
          load      = 1'b1;
          load_word = len64[63:32];
          wcnt_d    = wcnt_q + 4'd1;
          state_d   = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (can_load) begin
          load       = 1'b1;
          load_word  = len64[31:0];
          load_final = 1'b1;
          wcnt_d     = '0;
          bitlen_d   = '0;
          state_d    = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_word  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_final <= 1'b0;
    end else if (load) begin
      out_word  <= load_word;
      out_valid <= 1'b1;
      out_first <= (wcnt_q == 4'd0);
      out_final <= load_final;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_final <= 1'b0;
    end
  end

`ifdef SHA256_PADDER_BLKCNT_EN
  logic out_w15_q;
  logic busy_prev_q;
  logic msg_start;

  // A new message may start in the same cycle the previous final word leaves.
  assign msg_start = accept && (!busy_q || (out_fire && out_final));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_w15_q   <= 1'b0;
      busy_prev_q <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      busy_prev_q <= busy_q;
      if (load) begin
        out_w15_q <= (wcnt_q == LAST_BLOCK_WORD);
      end
      if (msg_start || (busy_prev_q && !busy_q)) begin
        blk_cnt <= '0;
      end else if (out_fire && out_w15_q) begin
        blk_cnt <= blk_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed self-checking bench for sha256_msg_padder; expected words come from a
// byte-level FIPS 180-4 padding model plus hand-computed constants.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_nodata;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_final;
  logic        busy;
`ifdef SHA256_PADDER_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  always #5 clk = ~clk;

  sha256_msg_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_nodata (in_nodata),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_final (out_final),
    .busy      (busy)
`ifdef SHA256_PADDER_BLKCNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  logic [31:0] got_w[$];
  bit          got_f[$];
  bit          got_l[$];
  logic [31:0] exp_w[$];
  logic [7:0]  msg[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s observed=timeout expected=progress", tag);
  endtask

  function automatic void build_exp(input logic [7:0] m[$]);
    logic [7:0]      b[$];
    longint unsigned bits;
    b = m;
    bits = longint'(m.size()) * 8;
    b.push_back(8'h80);
    while ((b.size() % 64) != 56) b.push_back(8'h00);
    for (int i = 7; i >= 0; i--) b.push_back(8'(bits >> (8 * i)));
    exp_w.delete();
    for (int i = 0; i < b.size(); i += 4) exp_w.push_back({b[i], b[i+1], b[i+2], b[i+3]});
  endfunction

  task automatic beat(input logic [7:0] d, input bit last, input bit nod);
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_nodata = nod;
    #1;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) timeout("in_ready_wait");
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nodata = 1'b0;
    in_data   = 8'h00;
  endtask

  task automatic send_msg(input logic [7:0] m[$], input bit nodata);
    if (nodata) beat(8'h00, 1'b1, 1'b1);
    else for (int i = 0; i < m.size(); i++) beat(m[i], i == m.size() - 1, 1'b0);
    idle_inputs();
  endtask

  task automatic collect(input int n);
    int          guard = 0;
    bit          hold = 1'b0;
    logic [31:0] held = '0;
    got_w.delete(); got_f.delete(); got_l.delete();
    while (got_w.size() < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (hold) begin
        chk("hold_word", out_word, held);
        chk("hold_valid", out_valid, 1'b1);
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        got_w.push_back(out_word);
        got_f.push_back(out_first);
        got_l.push_back(out_final);
      end
      hold = out_valid && !out_ready;
      held = out_word;
    end
    if (got_w.size() < n) timeout("collect");
    out_ready = 1'b1;
  endtask

  task automatic run(input logic [7:0] m[$], input bit nodata, input int n);
    fork
      send_msg(m, nodata);
      collect(n);
    join
  endtask

  task automatic verify(input string tag);
    chk({tag, "_count"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
      chk($sformatf("%s_first%0d", tag, i), got_f[i], (i % 16) == 0);
      chk($sformatf("%s_final%0d", tag, i), got_l[i], i == exp_w.size() - 1);
    end
    repeat (3) @(negedge clk);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_valid_end"}, out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_nodata = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_flags", {out_first, out_final}, 2'b00);
    rst = 1'b0;

    // "abc"
    msg = '{8'h61, 8'h62, 8'h63};
    build_exp(msg);
    run(msg, 1'b0, 16);
    chk("abc_w0_hand", got_w[0], 32'h61626380);
    chk("abc_w15_hand", got_w[15], 32'h00000018);
    verify("abc");

    // zero-length message via terminator-only beat
    msg.delete();
    build_exp(msg);
    run(msg, 1'b1, 16);
    chk("empty_w0_hand", got_w[0], 32'h80000000);
    chk("empty_w15_hand", got_w[15], 32'h00000000);
    verify("empty");

    // 55 zero bytes: terminator lands in the last lane of word 13
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'h00);
    build_exp(msg);
    run(msg, 1'b0, 16);
    chk("z55_w13_hand", got_w[13], 32'h00000080);
    chk("z55_w15_hand", got_w[15], 32'h000001B8);
    verify("z55");

    // 56 zero bytes: length no longer fits, second block needed
    msg.push_back(8'h00);
    build_exp(msg);
    run(msg, 1'b0, 32);
    chk("z56_w14_hand", got_w[14], 32'h80000000);
    chk("z56_w31_hand", got_w[31], 32'h000001C0);
    verify("z56");

    // 64 bytes of 'A': terminator is a fresh word 0 of block 2
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'h41);
    build_exp(msg);
    run(msg, 1'b0, 32);
`ifdef SHA256_PADDER_BLKCNT_EN
    @(posedge clk); #1;
    chk("a64_blk_cnt", blk_cnt, 16'd2);
`endif
    chk("a64_w15_hand", got_w[15], 32'h41414141);
    chk("a64_w16_hand", got_w[16], 32'h80000000);
    chk("a64_w31_hand", got_w[31], 32'h00000200);
    verify("a64");

    // 200 random bytes with 50% backpressure
    msg.delete();
    for (int i = 0; i < 200; i++) msg.push_back(8'($urandom_range(0, 255)));
    build_exp(msg);
    rand_ready = 1'b1;
    run(msg, 1'b0, 64);
    rand_ready = 1'b0;
    chk("r200_w63_hand", got_w[63], 32'h00000640);
    verify("r200");

    // reset mid-message, then "abc" again
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) beat(8'h5A, 1'b0, 1'b0);
    idle_inputs();
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_rst_busy_held", busy, 1'b0);
    rst = 1'b0;
    msg = '{8'h61, 8'h62, 8'h63};
    build_exp(msg);
    run(msg, 1'b0, 16);
    chk("post_rst_w0_hand", got_w[0], 32'h61626380);
    chk("post_rst_w15_hand", got_w[15], 32'h00000018);
    verify("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
